// File: rtl/div_pkg.sv
// Shared encodings for the sequential divider.
package div_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Controller-to-divider handshake and result bus.
interface seq_divider_if #(parameter int W = 8);
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (output start, is_signed, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, is_signed, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);
  // One extra bit: an unsigned divisor near 2^W lets the shifted remainder exceed W bits.
  logic [W:0] shifted;

  assign shifted = {rem, q_msb};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_nxt = q_bit ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per operation.
module seq_divider
  import div_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = $clog2(W)
) (
  input logic           clk,
  input logic           rst,
  seq_divider_if.slave  bus
);
  state_t        state, state_nxt;
  logic [W-1:0]  q_sh, rem_r, dvsr, quo_r, rmd_r;
  logic [W-1:0]  rem_nxt, dvd_mag, dvs_mag;
  logic [CW-1:0] cnt;
  logic          q_neg, r_neg, dvz, dbz_r, q_bit;
  logic          accept, dvs_zero, busy_c, done_c;

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign dvs_zero = (bus.divisor == '0);
  // Most-negative negates to itself, which reads correctly as unsigned 2^(W-1).
  assign dvd_mag  = (bus.is_signed && bus.dividend[W-1]) ? -bus.dividend : bus.dividend;
  assign dvs_mag  = (bus.is_signed && bus.divisor[W-1])  ? -bus.divisor  : bus.divisor;

  div_step #(.W(W)) u_step (
    .rem     (rem_r),
    .q_msb   (q_sh[W-1]),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = dvs_zero ? FIX : CALC;
      CALC: begin
        busy_c = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        busy_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = accept ? (dvs_zero ? FIX : CALC) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_sh  <= '0;
      rem_r <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dvz   <= 1'b0;
      quo_r <= '0;
      rmd_r <= '0;
      dbz_r <= 1'b0;
    end else begin
      if (accept) begin
        // A zero divisor skips CALC, so the shift register carries the raw dividend to FIX.
        q_sh  <= dvs_zero ? bus.dividend : dvd_mag;
        rem_r <= '0;
        dvsr  <= dvs_mag;
        cnt   <= CW'(W-1);
        q_neg <= bus.is_signed & (bus.dividend[W-1] ^ bus.divisor[W-1]);
        r_neg <= bus.is_signed & bus.dividend[W-1];
        dvz   <= dvs_zero;
      end else if (state == CALC) begin
        q_sh  <= {q_sh[W-2:0], q_bit};
        rem_r <= rem_nxt;
        cnt   <= cnt - CW'(1);
      end
      if (state == FIX) begin
        if (dvz) begin
          quo_r <= '1;
          rmd_r <= q_sh;
          dbz_r <= 1'b1;
        end else begin
          quo_r <= q_neg ? -q_sh : q_sh;
          rmd_r <= r_neg ? -rem_r : rem_r;
          dbz_r <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rmd_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: W=8 vector table and corner sequences, W=16 random regression.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.W(8))  bus8();
  seq_divider_if #(.W(16)) bus16();

  seq_divider #(.W(8))  u_div8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_divider #(.W(16)) u_div16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct { logic [15:0] q; logic [15:0] r; logic dz; } exp_t;
  typedef struct { logic s; logic [7:0] a; logic [7:0] b; logic [7:0] q; logic [7:0] r; logic dz; } vec_t;

  exp_t sb8[$];
  exp_t sb16[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result scoreboards: every done pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus8.done) begin
      chk("busy_with_done8", 32'(bus8.busy), 32'(0));
      if (sb8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done8: got done with empty scoreboard");
      end else begin
        e = sb8.pop_front();
        chk("quotient8",    32'(bus8.quotient),    32'(e.q[7:0]));
        chk("remainder8",   32'(bus8.remainder),   32'(e.r[7:0]));
        chk("div_by_zero8", 32'(bus8.div_by_zero), 32'(e.dz));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16.done) begin
      chk("busy_with_done16", 32'(bus16.busy), 32'(0));
      if (sb16.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done16: got done with empty scoreboard");
      end else begin
        e = sb16.pop_front();
        chk("quotient16",    32'(bus16.quotient),    32'(e.q));
        chk("remainder16",   32'(bus16.remainder),   32'(e.r));
        chk("div_by_zero16", 32'(bus16.div_by_zero), 32'(e.dz));
      end
    end
  end

  task automatic wait8(input int e0, output int edges, output int busy_n);
    edges = e0; busy_n = 0;
    while (!bus8.done && edges < 40) begin
      if (bus8.busy) busy_n++;
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic wait16(input int e0, output int edges);
    edges = e0;
    while (!bus16.done && edges < 60) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] q, input logic [7:0] r, input logic dz,
                     input int lat, input bit b2b, input string tag);
    int edges, busy_n;
    exp_t e;
    if (!b2b) @(negedge clk);
    bus8.start = 1'b1; bus8.is_signed = s; bus8.dividend = a; bus8.divisor = b;
    e.q = 16'(q); e.r = 16'(r); e.dz = dz;
    sb8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(1, edges, busy_n);
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat-1));
  endtask

  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic [15:0] r, input logic dz,
                      input int lat, input string tag);
    int edges;
    exp_t e;
    @(negedge clk);
    bus16.start = 1'b1; bus16.is_signed = s; bus16.dividend = a; bus16.divisor = b;
    e.q = q; e.r = r; e.dz = dz;
    sb16.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    wait16(1, edges);
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
  endtask

  function automatic void ref16(input logic s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa, sb, qi, ri;
    dz = (b == 16'd0);
    if (dz) begin
      q = 16'hFFFF; r = a;
    end else if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      qi = sa / sb; ri = sa % sb;
      q = qi[15:0]; r = ri[15:0];
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    int   edges, busy_n;
    logic s, dz;
    logic [15:0] a, b, q, r;

    tbl[0]  = '{1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0};
    tbl[1]  = '{1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0};
    tbl[2]  = '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h2A,  8'h00, 8'hFF,  8'h2A, 1'b1};
    tbl[4]  = '{1'b1, 8'h2A,  8'h00, 8'hFF,  8'h2A, 1'b1};
    tbl[5]  = '{1'b0, 8'd255, 8'd1,  8'hFF,  8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0};
    tbl[7]  = '{1'b1, 8'h80,  8'h03, 8'hD6,  8'hFE, 1'b0};
    tbl[8]  = '{1'b0, 8'h80,  8'h03, 8'h2A,  8'h02, 1'b0};
    tbl[9]  = '{1'b0, 8'd5,   8'd9,  8'd0,   8'd5,  1'b0};
    tbl[10] = '{1'b1, 8'hF9,  8'hF9, 8'h01,  8'h00, 1'b0};

    bus8.start = 1'b0;  bus8.is_signed = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
    bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.dividend = '0; bus16.divisor = '0;

    repeat (2) @(negedge clk);
    chk("rst_quotient",    32'(bus8.quotient),    32'(0));
    chk("rst_remainder",   32'(bus8.remainder),   32'(0));
    chk("rst_div_by_zero", 32'(bus8.div_by_zero), 32'(0));
    chk("rst_busy",        32'(bus8.busy),        32'(0));
    chk("rst_done",        32'(bus8.done),        32'(0));
    rst = 1'b1;

    for (int i = 0; i < 11; i++)
      op8(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz,
          (tbl[i].b == 8'd0) ? 2 : 10, 1'b0, $sformatf("vec%0d", i));

    // start held high with changing operands while busy must not disturb the first op
    @(negedge clk);
    bus8.start = 1'b1; bus8.is_signed = 1'b0; bus8.dividend = 8'd100; bus8.divisor = 8'd7;
    sb8.push_back('{16'd14, 16'd2, 1'b0});
    @(posedge clk);
    edges = 1;
    repeat (5) begin
      @(negedge clk);
      bus8.dividend = 8'($urandom); bus8.divisor = 8'd3; bus8.is_signed = 1'b1;
      @(posedge clk); edges++;
    end
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(edges, edges, busy_n);
    chk("held_start_latency", 32'(edges), 32'(10));

    // back-to-back: start in the DONE cycle
    op8(1'b0, 8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 10, 1'b0, "b2b_first");
    op8(1'b0, 8'd50,  8'd7,  8'd7,  8'd1, 1'b0, 10, 1'b1, "b2b_second");

    // reset mid-CALC abandons the operation
    @(negedge clk);
    bus8.start = 1'b1; bus8.is_signed = 1'b0; bus8.dividend = 8'd200; bus8.divisor = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_quotient",    32'(bus8.quotient),    32'(0));
    chk("midrst_remainder",   32'(bus8.remainder),   32'(0));
    chk("midrst_div_by_zero", 32'(bus8.div_by_zero), 32'(0));
    chk("midrst_busy",        32'(bus8.busy),        32'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(bus8.done), 32'(0));
    end
    op8(1'b0, 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 10, 1'b0, "after_rst");

    // W=16
    op16(1'b0, 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 18, "w16_hand");
    for (int i = 0; i < 60; i++) begin
      s = 1'(i % 2);
      a = (i % 7 == 3) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        3:       b = 16'h8000;
        default: b = 16'($urandom);
      endcase
      ref16(s, a, b, q, r, dz);
      op16(s, a, b, q, r, dz, dz ? 2 : 18, $sformatf("w16_rand%0d", i));
    end

    repeat (3) @(negedge clk);
    chk("sb8_pending",  32'(sb8.size()),  32'(0));
    chk("sb16_pending", 32'(sb16.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
